asmd_interpolator: RTL and testbench

Word-to-sample unpacker and optional 2x/3x interpolator: accepts 16-bit words carrying two 8-bit samples and emits them as an 8-bit sample stream. It is the downstream counterpart of the decimator in the ASMD sample path, which packs byte pairs into 16-bit words. Structure is a Moore-style ASMD controller plus a registered datapath. Both ports use a valid/ready handshake.

---
 rtl/asmd_interpolator.sv | 138 +++++++++++++
 tb/tb_asmd_interpolator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/asmd_interpolator.sv
// asmd_interpolator
//   Unpacks 16-bit words carrying two 8-bit samples (hi in [15:8], lo in [7:0])
//   into an 8-bit sample stream. With INTERP=1 an extra sample is inserted
//   between hi and lo: mid = floor((hi+lo)/2).
//   The controller is a Moore-style ASMD. Dout and Dout_valid come straight
//   from registers.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous, active-high reset
//   Clr        : synchronous abort; drops the held word and returns to idle
//   Din        : packed input word
//   Din_valid  : upstream word valid
//   Din_ready  : word accepted this cycle (combinational from state, Dout_ready, Clr)
//   Dout       : current sample (registered)
//   Dout_valid : Dout is valid (registered)
//   Dout_ready : downstream accepts Dout this cycle
module asmd_interpolator #(
    parameter logic INTERP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Clr,
    input  logic [15:0] Din,
    input  logic        Din_valid,
    output logic        Din_ready,
    output logic [7:0]  Dout,
    output logic        Dout_valid,
    input  logic        Dout_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_MID  = 2'd2,
        S_LO   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  w_hi_q, w_hi_d;
    logic [7:0]  w_lo_q, w_lo_d;
    logic [7:0]  dout_q, dout_d;
    logic        dvld_q, dvld_d;
    logic        in_xfer, out_xfer;

    // Floor average; the 9-bit sum keeps the carry so the result never wraps.
    function automatic logic [7:0] mid_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8:1];
    endfunction

    // A new word can enter while idle, or while lo is leaving in the same
    // cycle (back-to-back with no bubble). Clr blocks acceptance.
    assign Din_ready  = ((state_q == S_IDLE) | ((state_q == S_LO) & Dout_ready)) & ~Clr;
    assign in_xfer    = Din_valid & Din_ready;
    assign out_xfer   = dvld_q & Dout_ready;
    assign Dout       = dout_q;
    assign Dout_valid = dvld_q;

    always_comb begin
        state_d = state_q;
        w_hi_d  = w_hi_q;
        w_lo_d  = w_lo_q;
        dout_d  = dout_q;
        dvld_d  = dvld_q;

        if (Clr) begin
            // Abort: Dout and the held word keep their values, only valid drops.
            state_d = S_IDLE;
            dvld_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_xfer) begin
                        state_d = S_HI;
                        w_hi_d  = Din[15:8];
                        w_lo_d  = Din[7:0];
                        dout_d  = Din[15:8];
                        dvld_d  = 1'b1;
                    end
                end
                S_HI: begin
                    if (out_xfer) begin
                        if (INTERP) begin
                            state_d = S_MID;
                            dout_d  = mid_avg(w_hi_q, w_lo_q);
                        end else begin
                            state_d = S_LO;
                            dout_d  = w_lo_q;
                        end
                    end
                end
                S_MID: begin
                    if (out_xfer) begin
                        state_d = S_LO;
                        dout_d  = w_lo_q;
                    end
                end
                S_LO: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            state_d = S_HI;
                            w_hi_d  = Din[15:8];
                            w_lo_d  = Din[7:0];
                            dout_d  = Din[15:8];
                        end else begin
                            // Dout keeps the last sample; only valid drops.
                            state_d = S_IDLE;
                            dvld_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    dvld_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_hi_q  <= 8'h00;
            w_lo_q  <= 8'h00;
            dout_q  <= 8'h00;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_hi_q  <= w_hi_d;
            w_lo_q  <= w_lo_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
        end
    end

endmodule

// File: tb/tb_asmd_interpolator.sv
`timescale 1ns/1ps
module tb_asmd_interpolator;

    logic        clk;
    logic        rst;
    logic        clr        [2];
    logic [15:0] din        [2];
    logic        din_valid  [2];
    logic        din_ready  [2];
    logic [7:0]  dout       [2];
    logic        dout_valid [2];
    logic        dout_ready [2];

    int checks;
    int errors;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    bit done0, done1;

    // Index 0: plain unpacker, index 1: 3x interpolator.
    asmd_interpolator #(.INTERP(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .Clr(clr[0]), .Din(din[0]), .Din_valid(din_valid[0]),
        .Din_ready(din_ready[0]), .Dout(dout[0]), .Dout_valid(dout_valid[0]),
        .Dout_ready(dout_ready[0])
    );

    asmd_interpolator #(.INTERP(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .Clr(clr[1]), .Din(din[1]), .Din_valid(din_valid[1]),
        .Din_ready(din_ready[1]), .Dout(dout[1]), .Dout_valid(dout_valid[1]),
        .Dout_ready(dout_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the sample sequence a word must produce.
    task automatic push_word(input int m, input logic [15:0] w);
        logic [7:0] hi, lo, mid;
        hi  = w[15:8];
        lo  = w[7:0];
        mid = 8'((int'(hi) + int'(lo)) / 2);
        if (m == 0) begin
            q0.push_back(hi);
            q0.push_back(lo);
        end else begin
            q1.push_back(hi);
            q1.push_back(mid);
            q1.push_back(lo);
        end
    endtask

    task automatic flush(input int m);
        if (m == 0) q0.delete();
        else        q1.delete();
    endtask

    // Monitor: every accepted output sample is compared against the model queue.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int m = 0; m < 2; m++) begin
                    if (dout_valid[m] && dout_ready[m] && !clr[m]) begin
                        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_sample dut%0d: got %h, expected none", m, dout[m]);
                        end else begin
                            if (m == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            chk($sformatf("sample dut%0d", m), {8'h00, dout[m]}, {8'h00, e});
                        end
                    end
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int m, input logic [15:0] w);
        din[m]       = w;
        din_valid[m] = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (din_ready[m]) begin
                push_word(m, w);
                @(posedge clk);
                #1;
                din_valid[m] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout dut%0d: word %h not accepted, expected accept", m, w);
        din_valid[m] = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((q0.size() != 0 || q1.size() != 0) && c < 500) begin
            @(posedge clk);
            c++;
        end
        if (c >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d/%0d, expected 0/0", q0.size(), q1.size());
            flush(0);
            flush(1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_sender(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(m, 16'($urandom));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int m = 0; m < 2; m++) begin
            clr[m] = 1'b0; din[m] = 16'h0; din_valid[m] = 1'b0; dout_ready[m] = 1'b1;
        end
        fork monitor(); join_none

        // Reset / idle
        #3;
        chk("reset_dout0", {8'h0, dout[0]}, 16'h0000);
        chk("reset_vld0", {15'h0, dout_valid[0]}, 16'h0000);
        chk("reset_dout1", {8'h0, dout[1]}, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("idle_rdy0", {15'h0, din_ready[0]}, 16'h0001);
        chk("idle_rdy1", {15'h0, din_ready[1]}, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_vld0", {15'h0, dout_valid[0]}, 16'h0000);
        chk("idle_vld1", {15'h0, dout_valid[1]}, 16'h0000);

        // Asynchronous reset in the middle of a word
        dout_ready[1] = 1'b0;
        send(1, 16'h5A3C);
        #3;
        chk("pre_rst_vld", {15'h0, dout_valid[1]}, 16'h0001);
        chk("pre_rst_dout", {8'h0, dout[1]}, 16'h005A);
        rst = 1'b1;
        #1;
        chk("async_rst_dout", {8'h0, dout[1]}, 16'h0000);
        chk("async_rst_vld", {15'h0, dout_valid[1]}, 16'h0000);
        flush(1);
        dout_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic unpack, INTERP=0
        send(0, 16'hA050);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("a050_vld_drop", {15'h0, dout_valid[0]}, 16'h0000);
        chk("a050_q_empty", 16'(q0.size()), 16'd0);
        drain();

        // Interpolation, INTERP=1
        send(1, 16'hA050);
        send(1, 16'h1102);
        send(1, 16'hFFFF);
        drain();

        // Back-to-back stream, INTERP=0
        fork
            begin
                send(0, 16'h1234);
                send(0, 16'h5678);
                send(0, 16'h9ABC);
            end
            begin
                int c;
                c = 0;
                @(negedge clk);
                while (!dout_valid[0] && c < 20) begin
                    @(negedge clk);
                    c++;
                end
                for (int i = 0; i < 6; i++) begin
                    chk($sformatf("stream_vld[%0d]", i), {15'h0, dout_valid[0]}, 16'h0001);
                    chk($sformatf("stream_rdy[%0d]", i), {15'h0, din_ready[0]}, 16'((i % 2) == 1));
                    @(negedge clk);
                end
                chk("stream_vld_end", {15'h0, dout_valid[0]}, 16'h0000);
            end
        join
        drain();

        // Backpressure while presenting hi
        dout_ready[0] = 1'b0;
        send(0, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_dout", {8'h0, dout[0]}, 16'h0012);
            chk("bp_vld", {15'h0, dout_valid[0]}, 16'h0001);
            chk("bp_rdy", {15'h0, din_ready[0]}, 16'h0000);
            @(posedge clk);
            #1;
        end
        dout_ready[0] = 1'b1;
        drain();

        // Clr while presenting mid
        send(1, 16'hA050);
        @(posedge clk);
        #1;
        clr[1] = 1'b1;
        @(negedge clk);
        chk("clr_rdy", {15'h0, din_ready[1]}, 16'h0000);
        chk("clr_mid", {8'h0, dout[1]}, 16'h0078);
        @(posedge clk);
        #1;
        clr[1] = 1'b0;
        chk("clr_vld", {15'h0, dout_valid[1]}, 16'h0000);
        chk("clr_dout_kept", {8'h0, dout[1]}, 16'h0078);
        flush(1);
        @(negedge clk);
        chk("clr_idle_rdy", {15'h0, din_ready[1]}, 16'h0001);
        @(posedge clk);
        #1;
        send(1, 16'h0F0E);
        drain();

        // Randomized traffic with random backpressure on both instances
        done0 = 1'b0;
        done1 = 1'b0;
        fork
            begin rand_sender(0, 40); done0 = 1'b1; end
            begin rand_sender(1, 40); done1 = 1'b1; end
            begin
                while (!(done0 && done1)) begin
                    @(posedge clk);
                    #1;
                    dout_ready[0] = ($urandom_range(0, 3) != 0);
                    dout_ready[1] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        dout_ready[0] = 1'b1;
        dout_ready[1] = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
